// File: rtl/seven_seg_mux.sv
// Multiplexed 7-segment display driver: shadow capture, frame-buffered scan with
// inter-digit blanking, leading-zero suppression, decimal points and pin polarity.
module seven_seg_mux #(
    parameter int NUM_DIGITS     = 6,
    parameter int DIGIT_TICKS    = 1000,
    parameter int BLANK_TICKS    = 50,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] disp,
    input  logic                    dispValid,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_strobe
);

    localparam int DW   = 4 * NUM_DIGITS;
    localparam int SW   = DW + NUM_DIGITS;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TMAX = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic          SEG_INV    = (SEG_ACTIVE_LOW != 0);
    localparam logic          DIG_INV    = (DIG_ACTIVE_LOW != 0);
    localparam logic          HAS_BLANK  = (BLANK_TICKS > 0);

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    state_t          state_q, state_d;
    logic [IW-1:0]   index_q, index_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [SW-1:0]   shadow_q, shadow_d;
    logic [SW-1:0]   frame_q, frame_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
    logic            strobe_q, strobe_d;

    logic            advance_s;
    logic            wrap_s;
    logic [DW-1:0]   frame_disp_s;
    logic [NUM_DIGITS-1:0] frame_dp_s;
    logic [DW-1:0]   tail_s;
    logic [3:0]      nib_s;
    logic [6:0]      lit_seg_s;
    logic [NUM_DIGITS-1:0] onehot_s;

    // Scan sequencing: dwell/blank timer, digit index, frame load at index wrap.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        timer_d   = timer_q;
        advance_s = 1'b0;
        wrap_s    = 1'b0;
        case (state_q)
            ST_SHOW: begin
                if (timer_q == DIGIT_LAST) begin
                    timer_d = '0;
                    if (HAS_BLANK) begin
                        state_d = ST_BLANK;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_BLANK: begin
                if (timer_q == BLANK_LAST) begin
                    timer_d   = '0;
                    state_d   = ST_SHOW;
                    advance_s = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SHOW;
                timer_d = '0;
            end
        endcase
        if (advance_s) begin
            if (index_q == LAST_IDX) begin
                index_d = '0;
                wrap_s  = 1'b1;
            end else begin
                index_d = index_q + 1'b1;
            end
        end else begin
            index_d = index_d;
        end
        // Frame takes the pre-edge shadow, so a capture in the wrap cycle waits a frame.
        frame_d  = wrap_s ? shadow_q : frame_q;
        shadow_d = dispValid ? {dp_en, disp} : shadow_q;
        strobe_d = wrap_s;
    end

    // Pin values for the digit currently selected by state/index.
    always_comb begin
        frame_disp_s = frame_q[DW-1:0];
        frame_dp_s   = frame_q[SW-1:DW];
        tail_s       = frame_disp_s >> {index_q, 2'b00};
        nib_s        = frame_disp_s[{index_q, 2'b00} +: 4];
        onehot_s     = NUM_DIGITS'(1'b1) << index_q;
        if (lz_blank && (index_q != '0) && (tail_s == '0)) begin
            lit_seg_s = 7'h00;
        end else begin
            lit_seg_s = hex_decode(nib_s);
        end
        seg_d    = {7{SEG_INV}};
        dp_d     = SEG_INV;
        dig_en_d = {NUM_DIGITS{DIG_INV}};
        if (state_q == ST_SHOW) begin
            seg_d    = lit_seg_s ^ {7{SEG_INV}};
            dp_d     = frame_dp_s[index_q] ^ SEG_INV;
            dig_en_d = onehot_s ^ {NUM_DIGITS{DIG_INV}};
        end else begin
            seg_d    = {7{SEG_INV}};
        end
    end

    // State, buffers and registered pins; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SHOW;
            index_q  <= '0;
            timer_q  <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            seg_q    <= {7{SEG_INV}};
            dp_q     <= SEG_INV;
            dig_en_q <= {NUM_DIGITS{DIG_INV}};
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            timer_q  <= timer_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            dig_en_q <= dig_en_d;
            strobe_q <= strobe_d;
        end
    end

    assign seg          = seg_q;
    assign dp           = dp_q;
    assign dig_en       = dig_en_q;
    assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: scan-position reference model driven by cycle arithmetic.
module tb_seven_seg_mux;

    localparam int ND    = 6;
    localparam int DT    = 4;
    localparam int BT    = 1;
    localparam int SLOT  = DT + BT;
    localparam int FRAME = ND * SLOT;

    logic            clk;
    logic            rst_n;
    logic [23:0]     disp;
    logic            dispValid;
    logic [5:0]      dp_en;
    logic            lz_blank;
    logic [6:0]      seg;
    logic            dp;
    logic [5:0]      dig_en;
    logic            frame_strobe;

    int total;
    int bad;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          m_cyc;
    logic [23:0] mf_disp, msh_disp;
    logic [5:0]  mf_dp, msh_dp;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [5:0]  exp_dig;
    logic        exp_strobe;

    seven_seg_mux #(
        .NUM_DIGITS(ND), .DIGIT_TICKS(DT), .BLANK_TICKS(BT),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .disp(disp), .dispValid(dispValid),
        .dp_en(dp_en), .lz_blank(lz_blank), .seg(seg), .dp(dp),
        .dig_en(dig_en), .frame_strobe(frame_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cyc    = 0;
        mf_disp  = 24'h0;
        mf_dp    = 6'h0;
        msh_disp = 24'h0;
        msh_dp   = 6'h0;
    endtask

    // Expected pins after the next edge follow from the position within the frame.
    task automatic tick();
        int pos;
        int d;
        logic [23:0] tail;
        pos = m_cyc % FRAME;
        d   = pos / SLOT;
        if (pos % SLOT >= DT) begin
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            exp_dig = 6'h3F;
        end else begin
            tail = mf_disp >> (4 * d);
            if (lz_blank && d > 0 && tail == 24'h0) exp_seg = 7'h7F;
            else exp_seg = tbl[tail[3:0]] ^ 7'h7F;
            exp_dp  = ~mf_dp[d];
            exp_dig = 6'h3F ^ (6'h01 << d);
        end
        exp_strobe = (pos == FRAME - 1);
        if (pos == FRAME - 1) begin
            mf_disp = msh_disp;
            mf_dp   = msh_dp;
        end
        if (dispValid) begin
            msh_disp = disp;
            msh_dp   = dp_en;
        end
        m_cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        dispValid = 1'b0;
        disp      = 24'h0;
        dp_en     = 6'h0;
        lz_blank  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({seg, dp, dig_en, frame_strobe} !== {7'h7F, 1'b1, 6'h3F, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold got seg=%h dp=%b dig=%h fs=%b want 7f 1 3f 0", seg, dp, dig_en, frame_strobe);
        end
        rst_n = 1'b1;
        model_reset();
        tick();
        total++;
        if ({seg, dp, dig_en} !== {7'h40, 1'b1, 6'h3E}) begin
            bad++;
            $display("FAIL reset_first_digit got seg=%h dp=%b dig=%h want 40 1 3e", seg, dp, dig_en);
        end
    endtask

    task automatic test_scan();
        int last_fs;
        do_reset();
        disp = 24'h12AB0F; dp_en = 6'h00; dispValid = 1'b1;
        tick();
        dispValid = 1'b0;
        total++;
        if ({seg, dp, dig_en, frame_strobe} !== {exp_seg, exp_dp, exp_dig, exp_strobe}) begin
            bad++;
            $display("FAIL scan cyc=%0d got %h %b %h %b want %h %b %h %b", m_cyc, seg, dp, dig_en, frame_strobe, exp_seg, exp_dp, exp_dig, exp_strobe);
        end
        last_fs = -1;
        for (int i = 0; i < 3 * FRAME + 5; i++) begin
            tick();
            total++;
            if ({seg, dp, dig_en, frame_strobe} !== {exp_seg, exp_dp, exp_dig, exp_strobe}) begin
                bad++;
                $display("FAIL scan cyc=%0d got %h %b %h %b want %h %b %h %b", m_cyc, seg, dp, dig_en, frame_strobe, exp_seg, exp_dp, exp_dig, exp_strobe);
            end
            if (frame_strobe === 1'b1) begin
                if (last_fs >= 0) begin
                    total++;
                    if (m_cyc - last_fs !== FRAME) begin
                        bad++;
                        $display("FAIL strobe_period got %0d want %0d", m_cyc - last_fs, FRAME);
                    end
                end
                last_fs = m_cyc;
            end
        end
    endtask

    task automatic test_anti_tear();
        int guard;
        guard = 0;
        while (!(exp_dig == 6'h37) && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 2 * FRAME) begin
            bad++;
            $display("FAIL tear_wait got timeout want digit 3 lit");
        end
        disp = 24'hFFFFFF; dispValid = 1'b1;
        tick();
        dispValid = 1'b0;
        for (int i = 0; i < 2 * FRAME + 3; i++) begin
            tick();
            total++;
            if ({seg, dp, dig_en, frame_strobe} !== {exp_seg, exp_dp, exp_dig, exp_strobe}) begin
                bad++;
                $display("FAIL tear cyc=%0d got %h %b %h %b want %h %b %h %b", m_cyc, seg, dp, dig_en, frame_strobe, exp_seg, exp_dp, exp_dig, exp_strobe);
            end
        end
    endtask

    task automatic test_lz_dp();
        logic [23:0] pats [3] = '{24'h000305, 24'h000000, 24'h0};
        logic [5:0]  dps  [3] = '{6'h00, 6'h00, 6'b000100};
        do_reset();
        pats[2] = 24'(($urandom() << 8) ^ $urandom());
        for (int p = 0; p < 3; p++) begin
            lz_blank = (p < 2);
            disp = pats[p]; dp_en = dps[p]; dispValid = 1'b1;
            tick();
            dispValid = 1'b0;
            for (int i = 0; i < 2 * FRAME + 2; i++) begin
                tick();
                total++;
                if ({seg, dp, dig_en, frame_strobe} !== {exp_seg, exp_dp, exp_dig, exp_strobe}) begin
                    bad++;
                    $display("FAIL lz_dp p=%0d cyc=%0d got %h %b %h %b want %h %b %h %b", p, m_cyc, seg, dp, dig_en, frame_strobe, exp_seg, exp_dp, exp_dig, exp_strobe);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 10 * FRAME; i++) begin
            dispValid = ($urandom_range(0, 7) == 0);
            disp      = 24'($urandom());
            dp_en     = 6'($urandom());
            if ($urandom_range(0, 31) == 0) lz_blank = ~lz_blank;
            tick();
            total++;
            if ({seg, dp, dig_en, frame_strobe} !== {exp_seg, exp_dp, exp_dig, exp_strobe}) begin
                bad++;
                $display("FAIL random cyc=%0d got %h %b %h %b want %h %b %h %b", m_cyc, seg, dp, dig_en, frame_strobe, exp_seg, exp_dp, exp_dig, exp_strobe);
            end
        end
        dispValid = 1'b0;
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        disp = 24'h654321; dp_en = 6'h3F; dispValid = 1'b1;
        tick();
        dispValid = 1'b0;
        while (!(exp_dig == 6'h2F && dig_en == 6'h2F) && guard < 3 * FRAME) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= 3 * FRAME) begin
            bad++;
            $display("FAIL areset_wait got timeout want digit 4 lit");
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({seg, dp, dig_en, frame_strobe} !== {7'h7F, 1'b1, 6'h3F, 1'b0}) begin
            bad++;
            $display("FAIL areset_immediate got seg=%h dp=%b dig=%h fs=%b want 7f 1 3f 0", seg, dp, dig_en, frame_strobe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        total++;
        if ({seg, dp, dig_en} !== {7'h40, 1'b1, 6'h3E}) begin
            bad++;
            $display("FAIL areset_restart got seg=%h dp=%b dig=%h want 40 1 3e", seg, dp, dig_en);
        end
        for (int i = 0; i < FRAME + 5; i++) begin
            tick();
            total++;
            if ({seg, dp, dig_en, frame_strobe} !== {exp_seg, exp_dp, exp_dig, exp_strobe}) begin
                bad++;
                $display("FAIL areset_scan cyc=%0d got %h %b %h %b want %h %b %h %b", m_cyc, seg, dp, dig_en, frame_strobe, exp_seg, exp_dp, exp_dig, exp_strobe);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        disp      = 24'h0;
        dispValid = 1'b0;
        dp_en     = 6'h0;
        lz_blank  = 1'b0;
        model_reset();
        test_reset();
        test_scan();
        test_anti_tear();
        test_lz_dp();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
Consumes the packed hex display word and its valid flag from the keypad/UI controller, and drives a multiplexed common-segment 7-segment display, one digit at a time. Includes an anti-tearing frame buffer, an inter-digit ghosting blank interval, optional leading-zero blanking, per-digit decimal points, and selectable output polarity. Sits between the UI controller and the board display pins.

Parameters:
NUM_DIGITS, 6, number of display digits; disp width is 4*NUM_DIGITS.
DIGIT_TICKS, 1000, clk cycles each digit is lit (>=1).
BLANK_TICKS, 50, clk cycles all digits are dark between digits (0 = no blank interval).
SEG_ACTIVE_LOW, 1, 1 = seg/dp pins drive low to light.
DIG_ACTIVE_LOW, 1, 1 = dig_en pins drive low to enable.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
disp  input  4*NUM_DIGITS  packed hex digits; nibble k shows on digit k, where digit 0 is disp[3:0]
dispValid  input  1  disp is valid this cycle; captured into the shadow register
dp_en  input  NUM_DIGITS  decimal-point request per digit; captured together with disp
lz_blank  input  1  1 = blank leading zero digits
seg  output  7  segments {g,f,e,d,c,b,a}, with polarity per SEG_ACTIVE_LOW
dp  output  1  decimal point, with polarity per SEG_ACTIVE_LOW
dig_en  output  NUM_DIGITS  one-hot digit enable, with polarity per DIG_ACTIVE_LOW
frame_strobe  output  1  one-cycle pulse when the frame buffer loads

Behaviour:
- Capture: any cycle with dispValid=1 loads shadow <= {dp_en, disp}. Reset value of shadow is 0.
- Frame buffer: loads from shadow only at a frame boundary, so a frame never mixes two disp values.
  - A frame boundary is the cycle the digit index wraps from NUM_DIGITS-1 to 0.
  - frame_strobe=1 in that same cycle.
  - A dispValid in the boundary cycle is not visible until the following frame.
- Index, timer and state:
  - Reset values: state=SHOW, index=0, timer=0, frame=0.
  - SHOW: timer counts 0..DIGIT_TICKS-1. At terminal count, timer is cleared and:
    - if BLANK_TICKS>0, go to BLANK;
    - otherwise advance the index and stay in SHOW.
  - BLANK: timer counts 0..BLANK_TICKS-1. At terminal count, timer is cleared, the index advances, and state returns to SHOW.
  - Index advance: index+1, wrapping NUM_DIGITS-1 -> 0. The wrap is the frame boundary and loads the frame.
- Outputs are registered, one cycle after the state/index they reflect.
  - In SHOW: dig_en is one-hot on the index, seg=decode(frame nibble[index]), dp=frame dp bit[index].
  - In BLANK: dig_en, seg and dp are all inactive.
  - Reset value of every output is inactive (polarity-adjusted); frame_strobe=0.
- Decode (active-high form, hex), nibbles 0-F:
  - 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Leading-zero blanking (lz_blank=1): digit k>0 is dark when every nibble k..NUM_DIGITS-1 of the frame is 0.
  - A dark digit has seg inactive and dp still honoured; its dig_en still asserts.
  - Digit 0 always shows. An all-zero frame shows a single "0".
  - lz_blank is sampled live, not frame-buffered.
- Polarity: the final seg/dp are XORed with SEG_ACTIVE_LOW, and dig_en with DIG_ACTIVE_LOW.
- Reset mid-scan returns all state to reset values and blanks outputs immediately (asynchronously). The first lit digit after release is digit 0, showing 0.
- One full frame lasts NUM_DIGITS*(DIGIT_TICKS+BLANK_TICKS) cycles.

Test Plan:
- Bench config NUM_DIGITS=6, DIGIT_TICKS=4, BLANK_TICKS=1, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1.
- Reset, then hold rst_n=0.
  - Required: seg=7F, dp=1, dig_en=3F.
  - After release, the first lit digit is dig_en=3E with seg=~3F&7F=40 (digit 0 showing "0").
- Reset, then dispValid pulse with disp=24'h12AB0F, lz_blank=0; wait one frame boundary.
  - Digits 0..5 show active-high 71,3F,7C,77,5B,06, each for 4 cycles.
  - Each digit is separated by 1 all-dark cycle.
  - frame_strobe pulses every 30 cycles.
- Anti-tearing: while digit 3 is lit, drive disp=24'hFFFFFF.
  - Digits 4 and 5 still show the old values.
  - All digits show 71 only after the next frame_strobe.
- lz_blank=1 with disp=24'h000305.
  - Digits 3..5 are dark while their dig_en still asserts.
  - Digits 0..2 show 6D,3F,4F.
  - With disp=0, only digit 0 lights, showing 3F.
- dp_en=6'b000100 loaded with any disp: dp is active only during digit 2 SHOW cycles.
- Assert rst_n=0 asynchronously mid-digit-4.
  - Outputs go inactive within the same cycle, without waiting for a clock edge.
  - After release, the scan restarts at digit 0 with frame=0.
